// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the rising-edge detector.
package edge_det_pkg;

  // Per-channel FSM state. Encoding value 3 is unused and recovers to ZERO.
  typedef enum logic [1:0] {
    ZERO = 2'd0,  // input seen low
    EDGE = 2'd1,  // rising edge just seen, tick asserted
    ONE  = 2'd2   // input held high
  } edge_state_t;

  localparam int SYNC_STAGES_MAX = 4;

  // Legal synchronizer depths: 0 (input already synchronous) or 2..SYNC_STAGES_MAX.
  function automatic logic sync_stages_legal(input int n);
    return (n == 0) || ((n >= 2) && (n <= SYNC_STAGES_MAX));
  endfunction

  // The only state that drives the output pulse.
  function automatic logic is_tick_state(input edge_state_t s);
    return (s == EDGE);
  endfunction

endpackage

// File: rtl/positive_edge_fsm.sv
// One channel of the rising-edge detector: 3-state Moore FSM with a
// registered tick. The tick flop is loaded from the next state, so it is
// high exactly while the state register holds EDGE and has no combinational
// path from lv.
module positive_edge_fsm
  import edge_det_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       lv,
  output logic       tick,
  output logic [1:0] state_dbg
);

  edge_state_t state_q, state_d;
  logic        tick_q, tick_d;

  // Next-state decode; unused encoding falls back to ZERO.
  always_comb begin
    state_d = ZERO;
    case (state_q)
      ZERO:    state_d = lv ? EDGE : ZERO;
      EDGE:    state_d = lv ? ONE  : ZERO;
      ONE:     state_d = lv ? ONE  : ZERO;
      default: state_d = ZERO;
    endcase
    tick_d = is_tick_state(state_d);
  end

  // State and tick registers; reset clears both immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ZERO;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
    end
  end

  assign tick      = tick_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/positive_edge_detector.sv
// Multi-channel rising-edge detector: optional per-bit input synchronizer
// followed by one independent edge FSM per channel. state_dbg exposes each
// channel's FSM state (2 bits per channel, channel i at [2*i+1:2*i]).
module positive_edge_detector
  import edge_det_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     level,
  output logic [WIDTH-1:0]     tick,
  output logic [2*WIDTH-1:0]   state_dbg
);

  // Reject illegal synchronizer depths at elaboration.
  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync
    $error("positive_edge_detector: SYNC_STAGES must be 0 or 2..4");
  end

  if (WIDTH < 1) begin : g_bad_width
    $error("positive_edge_detector: WIDTH must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic lv;

    if (SYNC_STAGES >= 2) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Synchronizer shift chain; cleared by reset so no stale level survives.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], level[i]};
        end
      end

      assign lv = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign lv = level[i];
    end

    positive_edge_fsm u_fsm (
      .clk       (clk),
      .rst       (rst),
      .lv        (lv),
      .tick      (tick[i]),
      .state_dbg (state_dbg[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_positive_edge_detector.sv
// Directed bench for positive_edge_detector: a WIDTH=1/SYNC_STAGES=0 instance
// and a WIDTH=4/SYNC_STAGES=2 instance sharing clock and reset.
module tb_positive_edge_detector;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [0:0] level0;
  logic [0:0] tick0;
  logic [1:0] state0;

  logic [3:0] level4;
  logic [3:0] tick4;
  logic [7:0] state4;

  positive_edge_detector #(.WIDTH(1), .SYNC_STAGES(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .level     (level0),
    .tick      (tick0),
    .state_dbg (state0)
  );

  positive_edge_detector #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .level     (level4),
    .tick      (tick4),
    .state_dbg (state4)
  );

  // ---------------- counters / checks ----------------
  int n_cmp;
  int n_err;
  int tick_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp    = 0;
    n_err    = 0;
    tick_cnt = 0;
    rst      = 1'b1;
    level0   = 1'b0;
    level4   = 4'b0000;

    // Reset state
    step(); step();
    check("rst_tick0",  tick0,  0);
    check("rst_tick4",  tick4,  0);
    check("rst_state0", state0, 0);
    check("rst_state4", state4, 0);

    // Reset then edge
    rst = 1'b0;
    step();  check("t1_idle",  tick0, 0);
    level0 = 1'b1;
    step();  check("t1_tick",  tick0, 1);
             check("t1_state_edge", state0, 1);
    step();  check("t1_drop",  tick0, 0);
             check("t1_state_one", state0, 2);
    step();  check("t1_hold",  tick0, 0);

    // Level high at reset exit
    rst = 1'b1;
    #1;      check("t2_async_state", state0, 0);
    step();  check("t2_in_rst", tick0, 0);
    rst = 1'b0;
    step();  check("t2_exit_tick", tick0, 1);
    step();  check("t2_exit_drop", tick0, 0);
    step();  check("t2_exit_hold", tick0, 0);

    // Toggle pattern: 1,1,0,0,1,1 -> ticks 4 cycles apart
    level0 = 1'b0;
    step(); step();
    check("t3_low_state", state0, 0);
    level0 = 1'b1;
    step();  check("t3_tick_a",  tick0, 1);
    step();  check("t3_hold_a",  tick0, 0);
    level0 = 1'b0;
    step();  check("t3_low_a",   tick0, 0);
    step();  check("t3_low_b",   tick0, 0);
    level0 = 1'b1;
    step();  check("t3_tick_b",  tick0, 1);
    step();  check("t3_hold_b",  tick0, 0);

    // Narrow pulses: 1,0,1,0 -> ticks on 1st and 3rd
    level0 = 1'b0;
    step();
    level0 = 1'b1; step(); check("t4_n1", tick0, 1);
    level0 = 1'b0; step(); check("t4_n2", tick0, 0);
    level0 = 1'b1; step(); check("t4_n3", tick0, 1);
    level0 = 1'b0; step(); check("t4_n4", tick0, 0);

    // One-cycle low gap between highs: 1,1,0,1 -> second tick
    level0 = 1'b1; step(); check("t5_g1", tick0, 1);
    level0 = 1'b1; step(); check("t5_g2", tick0, 0);
    level0 = 1'b0; step(); check("t5_g3", tick0, 0);
    level0 = 1'b1; step(); check("t5_g4", tick0, 1);
    level0 = 1'b0; step(); check("t5_g5", tick0, 0);

    // Async reset mid-tick drops tick before the next clock
    level0 = 1'b1;
    step();  check("t6_pre_tick", tick0, 1);
    #5 rst = 1'b1;
    #1       check("t6_async_drop", tick0, 0);
    #2 rst = 1'b0;
    level0 = 1'b0;
    step();  check("t6_after", tick0, 0);

    // Synchronized instance: bits 0 and 3 rise together, 2 cycles late
    level4 = 4'b1001;
    level0 = 1'b1;
    step();  check("t7_ref_tick", tick0, 1);
             check("t7_s1", tick4, 4'b0000);
    step();  check("t7_s2", tick4, 4'b0000);
    step();  check("t7_s3", tick4, 4'b1001);
    step();  check("t7_s4", tick4, 4'b0000);
    step();  check("t7_s5", tick4, 4'b0000);

    // Reset clears the synchronizer chain
    level4 = 4'b0110;
    step();
    rst = 1'b1;
    #1       check("t8_rst_tick4", tick4, 4'b0000);
    level4 = 4'b1001;
    step();
    rst = 1'b0;
    step();  check("t8_r1", tick4, 4'b0000);
             check("t8_d0_exit", tick0, 1);
    step();  check("t8_r2", tick4, 4'b0000);
    step();  check("t8_r3", tick4, 4'b1001);
    step();  check("t8_r4", tick4, 4'b0000);

    // Long hold: 100 cycles high -> exactly one tick
    level0 = 1'b0;
    step();
    level0 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      tick_cnt += int'(tick0);
    end
    check("t9_long_hold_count", tick_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/positive_edge_detector.md
# positive_edge_detector

Rising-edge detector that turns a slow or level-type input into a single-clock-cycle `tick` pulse for each low-to-high transition. It is used as a front-end conditioner for buttons, strobes and status flags ahead of counters and FSMs that need one event per edge. Each channel runs a 3-state Moore FSM with a registered output. An optional input synchronizer handles asynchronous sources.

## Interface
- `WIDTH`, default 1: number of independent channels.
- `SYNC_STAGES`, default 0: flip-flop synchronizer depth on `level`. 0 means `level` is already synchronous to `clk`. Legal values are 0 and 2..4.
- `clk`  in  1  rising-edge system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high; forces all state and outputs to idle.
- `level`  in  WIDTH  input levels, one bit per channel.
- `tick`  out  WIDTH  one-cycle pulse per detected rising edge, per channel.

## Operation
- Each channel is an independent Moore FSM. Channels share only `clk` and `rst`.
- States:
  - ZERO: input seen low.
  - EDGE: rising edge just seen; `tick` = 1.
  - ONE: input held high.
- Transitions are evaluated on each `clk` rising edge. `lv` is the post-synchronizer level.
  - ZERO: `lv`=1 -> EDGE; otherwise stay in ZERO.
  - EDGE: `lv`=1 -> ONE; `lv`=0 -> ZERO.
  - ONE: `lv`=0 -> ZERO; otherwise stay in ONE.
- `tick` is decoded from state only, so it is glitch-free and independent of the current `level`. It is registered (one-hot-friendly encoding, or an explicit tick flop).
- Reset:
  - State goes to ZERO, `tick` goes to 0, and synchronizer flops clear to 0. This takes effect immediately, without waiting for a clock.
  - If `level` is already high when reset releases, the first clock edge after release produces a tick. A high level at reset exit counts as a rising edge.
- Held-high input produces exactly one tick, however long it stays high.
- A level high for only one sampled cycle (ZERO->EDGE->ZERO) still produces one tick.
- A low pulse of one sampled cycle between two highs (ONE->ZERO->EDGE) produces a second tick.
- Input changes between clock edges that are not sampled are ignored.

## Timing
- Latency: `level` sampled high at edge k, with the previous sample low, gives `tick` high from just after edge k+SYNC_STAGES until just after edge k+SYNC_STAGES+1. Pulse width is always exactly 1 cycle.
- Minimum edge-to-edge spacing that still yields distinct ticks: 2 sampled cycles (one low, one high).
- Asserting `rst` mid-pulse drops `tick` to 0 asynchronously.
- Deasserting `rst` takes effect at the next `clk` rising edge. Deassertion must meet recovery/removal relative to `clk`; the integrator provides an external reset synchronizer.
- No combinational path from `level` to `tick`.

## Structure
- Shared package `edge_det_pkg`: state enum `edge_state_t` {ZERO, EDGE, ONE}, 2-bit encoding ZERO=0, EDGE=1, ONE=2; value 3 is illegal and recovers to ZERO.
- Sub-module `positive_edge_fsm`: one channel (clk, rst, lv -> tick). The top instantiates it WIDTH times in a generate loop, behind a per-bit synchronizer chain of SYNC_STAGES flops.
- Top level contains parameter checks (elaboration-time error on illegal `SYNC_STAGES`) and the generate loops only.

## Test plan
Clock period is 20 ns, WIDTH=1, SYNC_STAGES=0 unless stated.
- Reset then edge: `rst`=1, `level`=0 for 2 cycles; release `rst`; raise `level` at cycle 3 -> `tick`=1 for exactly one cycle after the next edge, then 0 while `level` stays high.
- Level high at reset exit: `rst`=1 with `level`=1; release `rst` -> exactly one tick on the first post-reset edge, then `tick`=0.
- Toggle pattern: `level` held 2 cycles each as 1, 0, 1 -> two ticks, 4 cycles apart, each 1 cycle wide.
- Narrow pulses: `level` = 1,0,1,0 on consecutive cycles -> ticks on cycles 1 and 3, none on 2 and 4. Async reset asserted mid-tick -> `tick` falls before the next clock.
- SYNC_STAGES=2, WIDTH=4: raise `level`[0] and `level`[3] in the same cycle -> ticks on bits 0 and 3 only, 2 cycles later than with SYNC_STAGES=0. Bits 1 and 2 stay 0.
- Long hold: `level`=1 for 100 cycles -> exactly one tick total.
